// File: rtl/serial_rca_adder_pkg.sv
// Shared definitions for the bit-serial ripple-carry adder: FSM states,
// the default operand width and the bit-counter width helper.
package serial_rca_adder_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must be able to hold the value WIDTH, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_rca_adder_pkg

// File: rtl/serial_rca_adder_full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder,
// reused on every ADD cycle.
module one_bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic half_sum;

    assign half_sum = a_i ^ b_i;
    assign s_o      = half_sum ^ c_i;
    assign c_o      = (a_i & b_i) | (half_sum & c_i);

endmodule : one_bit_full_adder

// File: rtl/serial_rca_adder.sv
// Bit-serial adder: {Cout,S} = A + B + Cin computed LSB first, one bit per
// clock, through a single full adder and a carry register.
module serial_rca_adder
    import serial_rca_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] acc_shift;

    one_bit_full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end

            ST_ADD: begin
                acc_d   = acc_shift;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_ONE;
                // Visible result only updates on DONE entry so S/Cout stay
                // frozen through IDLE and ADD of the next operation.
                if (cnt_q == LAST_CNT) begin
                    s_d     = acc_shift;
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule : serial_rca_adder

// File: tb/tb_serial_rca_adder.sv
// Scoreboard bench for serial_rca_adder (WIDTH=4): directed vectors push
// expected {Cout,S}; a negedge monitor pops and compares on each transfer.
module tb_serial_rca_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W:0] exp_q[$];
    logic       spacing_en = 1'b0;

    serial_rca_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s value=%0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout/unexpected required=event (cycle %0d)", name, cyc);
    endtask

    // Monitor: latency, spacing, and scoreboard compare on each transfer.
    initial begin
        int   acc_cyc   = 0;
        int   prev_rise = -1;
        logic ov_prev   = 1'b0;
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (!spacing_en) prev_rise = -1;
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    check("latency", cyc - acc_cyc, W);
                    check("in_ready_in_done", {31'd0, in_ready}, 0);
                    if (spacing_en && prev_rise >= 0)
                        check("b2b_spacing", cyc - prev_rise, W + 2);
                    prev_rise = cyc;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("sum", {28'd0, S}, {28'd0, e[W-1:0]});
                        check("cout", {31'd0, Cout}, {31'd0, e[W]});
                    end
                end
                if (in_valid && in_ready) acc_cyc = cyc + 1;
                ov_prev = out_valid;
            end
        end
    end

    // Caller is in the posedge+1 phase; returns in the same phase after the
    // accepting edge. hold keeps in_valid high afterwards.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input bit push, input bit hold);
        int n = 0;
        in_valid = hold;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        A = a; B = b; Cin = c; in_valid = 1'b1;
        if (push) exp_q.push_back({ec, es});
        @(posedge clk); #1;
        in_valid = hold;
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail_now(name);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
        idle_cycles(3);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_sum", {28'd0, S}, 0);
        check("rst_cout", {31'd0, Cout}, 0);

        // Basic additions, including full carry-out wrap.
        send(4'd3,  4'd5, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        send(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        send(4'd7,  4'd8, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        send(4'd6,  4'd5, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);
        idle_cycles(W + 3);

        // Consumer stall: result must hold steady while out_ready is low.
        out_ready = 1'b0;
        send(4'd9, 4'd6, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
        wait_out_valid("stall_wait");
        for (int i = 0; i < 5; i++) begin
            check("stall_sum", {28'd0, S}, 15);
            check("stall_cout", {31'd0, Cout}, 0);
            check("stall_out_valid", {31'd0, out_valid}, 1);
            check("stall_in_ready", {31'd0, in_ready}, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle_cycles(3);

        // Operands offered during ADD must be ignored.
        send(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
        A = 4'd15; B = 4'd15; Cin = 1'b1; in_valid = 1'b1;
        idle_cycles(2);
        in_valid = 1'b0;
        idle_cycles(W + 2);
        check("hold_sum_idle", {28'd0, S}, 4);
        check("hold_in_ready", {31'd0, in_ready}, 1);

        // Reset on the second ADD cycle aborts the operation.
        send(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", {31'd0, in_ready}, 1);
        check("abort_sum", {28'd0, S}, 0);
        check("abort_cout", {31'd0, Cout}, 0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) n++;
            @(posedge clk); #1;
        end
        check("abort_no_out_valid", n, 0);

        // Back-to-back with in_valid and out_ready held high.
        spacing_en = 1'b1;
        send(4'd10, 4'd7,  1'b1, 4'd2,  1'b1, 1'b1, 1'b1);
        send(4'd4,  4'd9,  1'b0, 4'd13, 1'b0, 1'b1, 1'b1);
        send(4'd12, 4'd12, 1'b1, 4'd9,  1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        spacing_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_rca_adder
